// File: rtl/qspi_sim_pkg.sv
// Shared types and helpers for the QSPI read-data latency emulator.
package qspi_sim_pkg;

    // Select indices are 4 bits wide, so up to 16 chip selects are supported.
    typedef logic [3:0] sel_idx_t;

    localparam logic [31:0] QSPI_IDLE_DATA = '0;

    function automatic int unsigned lat_width(input int unsigned max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/qspi_delay_ram.sv
// Circular history buffer (DATA_W x MAX_LAT) written every cycle, with an async read
// at a given offset behind the write pointer and a saturating fill counter.
module qspi_delay_ram #(
    parameter int DATA_W  = 4,
    parameter int MAX_LAT = 8,
    parameter int LAT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [LAT_W-1:0]  i_rd_lat,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid
);

    localparam int PTR_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int EXT_W = LAT_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_LAT - 1);
    localparam logic [LAT_W-1:0] MAX_FILL = LAT_W'(MAX_LAT);

    logic [DATA_W-1:0] r_buf [MAX_LAT];
    logic [PTR_W-1:0]  r_wp;
    logic [LAT_W-1:0]  r_fill;

    logic [EXT_W-1:0]  w_wp_ext;
    logic [EXT_W-1:0]  w_lat_ext;
    logic [EXT_W-1:0]  w_idx_ext;
    logic [PTR_W-1:0]  w_rd_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LAT; i++) begin
                r_buf[i] <= '0;
            end
            r_wp   <= '0;
            r_fill <= '0;
        end else begin
            r_buf[r_wp] <= i_wr_data;
            r_wp        <= (r_wp == LAST_PTR) ? '0 : r_wp + 1'b1;
            r_fill      <= (r_fill == MAX_FILL) ? r_fill : r_fill + 1'b1;
        end
    end

    // Modulo subtraction without relying on a power-of-two depth.
    always_comb begin
        w_wp_ext  = EXT_W'(r_wp);
        w_lat_ext = EXT_W'(i_rd_lat);
        if (w_wp_ext >= w_lat_ext) begin
            w_idx_ext = w_wp_ext - w_lat_ext;
        end else begin
            w_idx_ext = w_wp_ext + EXT_W'(MAX_LAT) - w_lat_ext;
        end
        w_rd_idx = PTR_W'(w_idx_ext);
    end

    assign o_rd_data  = r_buf[w_rd_idx];
    assign o_rd_valid = (i_rd_lat <= r_fill);

endmodule

// File: rtl/qspi_rx_delay_line.sv
// QSPI read-data latency emulator: per-select latency latched at transaction start.
// Optional protocol checker enabled by defining QSPI_DELAY_CHECK_EN.
module qspi_rx_delay_line
    import qspi_sim_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int MAX_LAT = 8,
    parameter int NUM_SEL = 3,
    localparam int LAT_W  = lat_width(MAX_LAT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [NUM_SEL-1:0]       sel_n,
    input  logic [NUM_SEL*LAT_W-1:0] lat_cfg,
    output logic [DATA_W-1:0]        data_out,
    output logic [LAT_W-1:0]         lat_act,
    output logic                     err
);

    localparam logic [LAT_W-1:0] MAX_LAT_L = LAT_W'(MAX_LAT);

    logic [NUM_SEL-1:0] r_sel_prev;
    logic [LAT_W-1:0]   r_lat_q;

    logic               w_start;
    sel_idx_t           w_sel_idx;
    logic [LAT_W-1:0]   w_lat_raw;
    logic [LAT_W-1:0]   w_lat_new;
    logic [LAT_W-1:0]   w_lat_cur;
    logic [DATA_W-1:0]  w_rd_data;
    logic               w_rd_valid;

    assign w_start = (&r_sel_prev) && !(&sel_n);

    // Lowest-index low select wins; scanning downward lets it overwrite the others.
    always_comb begin
        w_sel_idx = '0;
        for (int i = NUM_SEL - 1; i >= 0; i--) begin
            if (!sel_n[i]) begin
                w_sel_idx = sel_idx_t'(i);
            end
        end
        w_lat_raw = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            if (w_sel_idx == sel_idx_t'(i)) begin
                w_lat_raw = lat_cfg[i*LAT_W +: LAT_W];
            end
        end
    end

    assign w_lat_new = (w_lat_raw > MAX_LAT_L) ? MAX_LAT_L : w_lat_raw;
    assign w_lat_cur = w_start ? w_lat_new : r_lat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_prev <= '1;
            r_lat_q    <= '0;
        end else begin
            r_sel_prev <= sel_n;
            r_lat_q    <= w_lat_cur;
        end
    end

    qspi_delay_ram #(
        .DATA_W (DATA_W),
        .MAX_LAT(MAX_LAT),
        .LAT_W  (LAT_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_data (data_in),
        .i_rd_lat  (w_lat_cur),
        .o_rd_data (w_rd_data),
        .o_rd_valid(w_rd_valid)
    );

    always_comb begin
        data_out = DATA_W'(QSPI_IDLE_DATA);
        lat_act  = '0;
        if (!rst) begin
            lat_act = w_lat_cur;
            if (w_lat_cur == '0) begin
                data_out = data_in;
            end else if (w_rd_valid) begin
                data_out = w_rd_data;
            end
        end
    end

`ifdef QSPI_DELAY_CHECK_EN
    logic r_err;
    logic w_multi_low;
    logic w_over_lat;

    assign w_multi_low = ($countones(~sel_n) > 1);
    assign w_over_lat  = w_start && (w_lat_raw > MAX_LAT_L);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_multi_low | w_over_lat;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && !r_err && (w_multi_low || w_over_lat)) begin
            $display("qspi_rx_delay_line warning: multi_low=%0b over_lat=%0b sel_n=%b",
                     w_multi_low, w_over_lat, sel_n);
        end
    end
`endif

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_qspi_rx_delay_line.sv
// Scoreboard bench for qspi_rx_delay_line: stimulus pushes expectations, a negedge monitor checks.
module tb_qspi_rx_delay_line;

    localparam int DATA_W  = 4;
    localparam int MAX_LAT = 8;
    localparam int NUM_SEL = 3;
    localparam int LAT_W   = 4;

`ifdef QSPI_DELAY_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [DATA_W-1:0]        data_in = '0;
    logic [NUM_SEL-1:0]       sel_n = '1;
    logic [NUM_SEL*LAT_W-1:0] lat_cfg = '0;
    logic [DATA_W-1:0]        data_out;
    logic [LAT_W-1:0]         lat_act;
    logic                     err;

    logic [3:0] q_data [$];
    logic [3:0] q_lat  [$];
    logic       q_err  [$];
    int         q_step [$];

    int n_checks = 0;
    int n_errors = 0;
    int step_no  = 0;

    always #5 clk = ~clk;

    qspi_rx_delay_line #(
        .DATA_W (DATA_W),
        .MAX_LAT(MAX_LAT),
        .NUM_SEL(NUM_SEL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .sel_n   (sel_n),
        .lat_cfg (lat_cfg),
        .data_out(data_out),
        .lat_act (lat_act),
        .err     (err)
    );

    function automatic logic [11:0] cfg3(input logic [3:0] c2, input logic [3:0] c1,
                                         input logic [3:0] c0);
        return {c2, c1, c0};
    endfunction

    task automatic check(input string name, input int sid, input logic [3:0] act,
                         input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, sid, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] s, input logic [11:0] cfg,
                        input logic [3:0] d, input logic [3:0] ed, input logic [3:0] el,
                        input logic ee);
        @(posedge clk);
        #1;
        rst     = r;
        sel_n   = s;
        lat_cfg = cfg;
        data_in = d;
        step_no++;
        q_data.push_back(ed);
        q_lat.push_back(el);
        q_err.push_back(ee);
        q_step.push_back(step_no);
    endtask

    // Monitor: outputs are valid every cycle, so one expectation is consumed per negedge.
    always @(negedge clk) begin
        if (q_data.size() > 0) begin
            logic [3:0] ed;
            logic [3:0] el;
            logic       ee;
            int         sid;
            ed  = q_data.pop_front();
            el  = q_lat.pop_front();
            ee  = q_err.pop_front();
            sid = q_step.pop_front();
            check("data_out", sid, data_out, ed);
            check("lat_act", sid, lat_act, el);
            check("err", sid, {3'b0, err}, {3'b0, ee});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] hist [20];

        // Reset, then select 0 (latency 0): pass-through.
        step(1, 3'b110, cfg3(3, 2, 0), 4'h7, 4'h0, 4'd0, 0);
        step(1, 3'b110, cfg3(3, 2, 0), 4'h8, 4'h0, 4'd0, 0);
        step(0, 3'b110, cfg3(3, 2, 0), 4'h1, 4'h1, 4'd0, 0);
        step(0, 3'b110, cfg3(3, 2, 0), 4'h2, 4'h2, 4'd0, 0);
        step(0, 3'b110, cfg3(3, 2, 0), 4'h3, 4'h3, 4'd0, 0);
        // Direct switch to select 1 is not a start: latency stays 0.
        step(0, 3'b101, cfg3(3, 2, 0), 4'h4, 4'h4, 4'd0, 0);

        // Select 1, latency 2, from empty history.
        step(1, 3'b101, cfg3(3, 2, 0), 4'h9, 4'h0, 4'd0, 0);
        step(0, 3'b101, cfg3(3, 2, 0), 4'hA, 4'h0, 4'd2, 0);
        step(0, 3'b101, cfg3(3, 2, 0), 4'hB, 4'h0, 4'd2, 0);
        step(0, 3'b101, cfg3(3, 2, 0), 4'hC, 4'hA, 4'd2, 0);
        step(0, 3'b101, cfg3(3, 2, 0), 4'hD, 4'hB, 4'd2, 0);

        // Config change mid-transaction is ignored until the next start.
        step(0, 3'b101, cfg3(3, 5, 0), 4'hE, 4'hC, 4'd2, 0);
        step(0, 3'b101, cfg3(3, 5, 0), 4'hF, 4'hD, 4'd2, 0);
        step(0, 3'b111, cfg3(3, 5, 0), 4'h1, 4'hE, 4'd2, 0);
        step(0, 3'b101, cfg3(3, 5, 0), 4'h2, 4'hC, 4'd5, 0);
        step(0, 3'b101, cfg3(3, 5, 0), 4'h3, 4'hD, 4'd5, 0);

        // Oversize latency 12 is clamped to 8 at the next start.
        step(0, 3'b101, cfg3(3, 12, 0), 4'h4, 4'hE, 4'd5, 0);
        step(0, 3'b111, cfg3(3, 12, 0), 4'h5, 4'hF, 4'd5, 0);
        step(0, 3'b101, cfg3(3, 12, 0), 4'h6, 4'hD, 4'd8, 0);
        step(0, 3'b101, cfg3(3, 12, 0), 4'h7, 4'hE, 4'd8, CHK);

        // Select 2, latency 8, 20 words across the pointer wrap.
        step(1, 3'b011, cfg3(8, 2, 0), 4'h0, 4'h0, 4'd0, CHK);
        for (int i = 0; i < 20; i++) begin
            hist[i] = 4'((i * 3 + 1) % 16);
            step(0, 3'b011, cfg3(8, 2, 0), hist[i], (i < 8) ? 4'h0 : hist[i-8], 4'd8, 0);
        end

        // Reset mid-stream with latency 3: history is discarded.
        step(1, 3'b011, cfg3(3, 2, 0), 4'hA, 4'h0, 4'd0, 0);
        step(1, 3'b011, cfg3(3, 2, 0), 4'hB, 4'h0, 4'd0, 0);
        step(0, 3'b011, cfg3(3, 2, 0), 4'h1, 4'h0, 4'd3, 0);
        step(0, 3'b011, cfg3(3, 2, 0), 4'h2, 4'h0, 4'd3, 0);
        step(0, 3'b011, cfg3(3, 2, 0), 4'h3, 4'h0, 4'd3, 0);
        step(0, 3'b011, cfg3(3, 2, 0), 4'h4, 4'h1, 4'd3, 0);
        step(0, 3'b011, cfg3(3, 2, 0), 4'h5, 4'h2, 4'd3, 0);

        // Two selects low together: error only with the checker built in, sticky until reset.
        step(0, 3'b100, cfg3(3, 2, 0), 4'h6, 4'h3, 4'd3, 0);
        step(0, 3'b100, cfg3(3, 2, 0), 4'h7, 4'h4, 4'd3, CHK);
        step(0, 3'b111, cfg3(3, 2, 0), 4'h8, 4'h5, 4'd3, CHK);
        step(1, 3'b111, cfg3(3, 2, 0), 4'h0, 4'h0, 4'd0, CHK);
        step(0, 3'b111, cfg3(3, 2, 0), 4'h9, 4'h9, 4'd0, 0);

        @(negedge clk);
        #1;
        n_checks++;
        if (q_data.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", q_data.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
